dma_ch_arb: RTL and testbench

Two-channel burst arbiter and sequencer for the DMA channel-select datapath mux. It arbitrates between channel 0 and channel 1 burst requests and grants the AHB master port to one channel for a full burst. It drives the mux selector (`sel=1` routes channel 0, `sel=0` routes channel 1), counts beats against the granted length and reports completion or abort. It sits between the DMA channel register files and the AHB master interface.

---
 rtl/dma_ch_arb.sv | 186 ++++++++++++++++++
 tb/tb_dma_ch_arb.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_ch_arb.sv
// ---------------------------------------------------------------------------
// dma_ch_arb
//
// Two-channel burst arbiter and sequencer for the DMA channel-select mux.
// One channel owns the AHB master port for a whole burst. The block counts
// acknowledged beats against the length latched at grant time. It reports
// either normal completion or an abort, when the owner drops its request
// early.
//
// Parameters
//   BEAT_W    width of burst length / beat counter
//   PRI_MODE  0 = round-robin, 1 = fixed priority (channel 0 wins)
//
// Ports
//   clk, rst             clock, synchronous active-high reset
//   ch0_req, ch0_len     channel 0 burst request and length (beats)
//   ch1_req, ch1_len     channel 1 burst request and length (beats)
//   beat_ack             current beat accepted by the AHB master
//   ch0_gnt, ch1_gnt     bus ownership
//   sel                  mux select, 1 = channel 0, 0 = channel 1
//   bus_req              beats pending, master may issue transfers
//   beat_cnt             beats acknowledged in the current burst
//   burst_done           one-cycle pulse, burst completed
//   burst_abort          one-cycle pulse, owner dropped request early
// ---------------------------------------------------------------------------
module dma_ch_arb #(
    parameter int BEAT_W   = 8,
    parameter int PRI_MODE = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ch0_req,
    input  logic [BEAT_W-1:0] ch0_len,
    input  logic              ch1_req,
    input  logic [BEAT_W-1:0] ch1_len,
    input  logic              beat_ack,
    output logic              ch0_gnt,
    output logic              ch1_gnt,
    output logic              sel,
    output logic              bus_req,
    output logic [BEAT_W-1:0] beat_cnt,
    output logic              burst_done,
    output logic              burst_abort
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic              FIXED_PRI = (PRI_MODE != 0);
    localparam logic [BEAT_W-1:0] ONE       = BEAT_W'(1);

    state_t            state_reg, state_next;
    logic [BEAT_W-1:0] len_q_reg, len_q_next;
    logic              last_ch_reg, last_ch_next;   // channel index, 1 = ch1
    logic              ch0_gnt_reg, ch0_gnt_next;
    logic              ch1_gnt_reg, ch1_gnt_next;
    logic              sel_reg, sel_next;
    logic              bus_req_reg, bus_req_next;
    logic [BEAT_W-1:0] beat_cnt_reg, beat_cnt_next;
    logic              done_reg, done_next;
    logic              abort_reg, abort_next;

    // Per-channel views so eligibility is built uniformly.
    logic [1:0]        req_vec;
    logic [BEAT_W-1:0] len_arr [2];
    logic [1:0]        elig;

    assign req_vec    = {ch1_req, ch0_req};
    assign len_arr[0] = ch0_len;
    assign len_arr[1] = ch1_len;

    // A zero-length request is never eligible, so it can never win.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_elig
            assign elig[gi] = req_vec[gi] && (len_arr[gi] != '0);
        end
    endgenerate

    // Winner as a channel index. On a tie, round-robin picks the channel
    // that did not own the previous burst.
    logic win_idx;
    always_comb begin
        win_idx = 1'b0;
        if (elig == 2'b11) begin
            win_idx = FIXED_PRI ? 1'b0 : ~last_ch_reg;
        end else if (elig == 2'b10) begin
            win_idx = 1'b1;
        end
    end

    // The owner is identified by sel, which is stable for the whole burst.
    logic owner_req;
    logic last_beat;
    assign owner_req = sel_reg ? ch0_req : ch1_req;
    assign last_beat = beat_ack && (beat_cnt_reg == len_q_reg - ONE);

    always_comb begin
        state_next    = state_reg;
        len_q_next    = len_q_reg;
        last_ch_next  = last_ch_reg;
        ch0_gnt_next  = ch0_gnt_reg;
        ch1_gnt_next  = ch1_gnt_reg;
        sel_next      = sel_reg;
        bus_req_next  = bus_req_reg;
        beat_cnt_next = beat_cnt_reg;
        done_next     = 1'b0;
        abort_next    = 1'b0;

        case (state_reg)
            IDLE: begin
                if (elig != 2'b00) begin
                    state_next    = XFER;
                    len_q_next    = len_arr[win_idx];
                    ch0_gnt_next  = (win_idx == 1'b0);
                    ch1_gnt_next  = (win_idx == 1'b1);
                    sel_next      = ~win_idx;
                    bus_req_next  = 1'b1;
                    beat_cnt_next = '0;
                end
            end

            XFER: begin
                // The beat accepted in the final or the abort cycle still counts.
                if (beat_ack) begin
                    beat_cnt_next = beat_cnt_reg + ONE;
                end
                // Completion wins over a simultaneous request drop.
                if (last_beat || !owner_req) begin
                    state_next   = DONE;
                    done_next    = last_beat;
                    abort_next   = !last_beat;
                    ch0_gnt_next = 1'b0;
                    ch1_gnt_next = 1'b0;
                    bus_req_next = 1'b0;
                    last_ch_next = ~sel_reg;
                end
            end

            DONE: begin
                state_next = IDLE;
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            len_q_reg    <= '0;
            last_ch_reg  <= 1'b1;
            ch0_gnt_reg  <= 1'b0;
            ch1_gnt_reg  <= 1'b0;
            sel_reg      <= 1'b0;
            bus_req_reg  <= 1'b0;
            beat_cnt_reg <= '0;
            done_reg     <= 1'b0;
            abort_reg    <= 1'b0;
        end else begin
            state_reg    <= state_next;
            len_q_reg    <= len_q_next;
            last_ch_reg  <= last_ch_next;
            ch0_gnt_reg  <= ch0_gnt_next;
            ch1_gnt_reg  <= ch1_gnt_next;
            sel_reg      <= sel_next;
            bus_req_reg  <= bus_req_next;
            beat_cnt_reg <= beat_cnt_next;
            done_reg     <= done_next;
            abort_reg    <= abort_next;
        end
    end

    assign ch0_gnt     = ch0_gnt_reg;
    assign ch1_gnt     = ch1_gnt_reg;
    assign sel         = sel_reg;
    assign bus_req     = bus_req_reg;
    assign beat_cnt    = beat_cnt_reg;
    assign burst_done  = done_reg;
    assign burst_abort = abort_reg;

endmodule

// File: tb/tb_dma_ch_arb.sv
// ---------------------------------------------------------------------------
// tb_dma_ch_arb
//
// Drives one round-robin and one fixed-priority instance with shared
// stimulus. Each cycle a reference model predicts both instances' outputs.
// It pushes them to a queue. They are popped and compared after the edge.
// Directed checks cover the listed scenarios.
// ---------------------------------------------------------------------------
module tb_dma_ch_arb;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ch0_req = 1'b0, ch1_req = 1'b0, beat_ack = 1'b0;
    logic [7:0] ch0_len = 8'd0, ch1_len = 8'd0;

    logic       rr_ch0_gnt, rr_ch1_gnt, rr_sel, rr_bus_req, rr_burst_done, rr_burst_abort;
    logic [7:0] rr_beat_cnt;
    logic       fp_ch0_gnt, fp_ch1_gnt, fp_sel, fp_bus_req, fp_burst_done, fp_burst_abort;
    logic [7:0] fp_beat_cnt;

    always #5 clk = ~clk;

    dma_ch_arb #(.BEAT_W(8), .PRI_MODE(0)) u_rr (
        .clk(clk), .rst(rst),
        .ch0_req(ch0_req), .ch0_len(ch0_len), .ch1_req(ch1_req), .ch1_len(ch1_len),
        .beat_ack(beat_ack),
        .ch0_gnt(rr_ch0_gnt), .ch1_gnt(rr_ch1_gnt), .sel(rr_sel), .bus_req(rr_bus_req),
        .beat_cnt(rr_beat_cnt), .burst_done(rr_burst_done), .burst_abort(rr_burst_abort)
    );

    dma_ch_arb #(.BEAT_W(8), .PRI_MODE(1)) u_fp (
        .clk(clk), .rst(rst),
        .ch0_req(ch0_req), .ch0_len(ch0_len), .ch1_req(ch1_req), .ch1_len(ch1_len),
        .beat_ack(beat_ack),
        .ch0_gnt(fp_ch0_gnt), .ch1_gnt(fp_ch1_gnt), .sel(fp_sel), .bus_req(fp_bus_req),
        .beat_cnt(fp_beat_cnt), .burst_done(fp_burst_done), .burst_abort(fp_burst_abort)
    );

    logic [13:0] rr_vec, fp_vec;
    assign rr_vec = {rr_ch0_gnt, rr_ch1_gnt, rr_sel, rr_bus_req, rr_beat_cnt, rr_burst_done, rr_burst_abort};
    assign fp_vec = {fp_ch0_gnt, fp_ch1_gnt, fp_sel, fp_bus_req, fp_beat_cnt, fp_burst_done, fp_burst_abort};

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        if (obs !== expv) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, obs, expv);
        end
    endtask

    // Reference model. Index 0 = round-robin, 1 = fixed priority.
    // st: 0 idle, 1 transfer, 2 done. rem counts beats still owed.
    int   md_st[2], md_own[2], md_rem[2], md_cnt[2], md_last[2];
    logic md_sel[2], md_done[2], md_abort[2];

    task automatic model_step(input int m);
        logic e0, e1;
        int   w;
        logic [1:0] rq;
        rq = {ch1_req, ch0_req};
        md_done[m]  = 1'b0;
        md_abort[m] = 1'b0;
        if (rst) begin
            md_st[m] = 0; md_cnt[m] = 0; md_sel[m] = 1'b0; md_last[m] = 1;
            md_own[m] = 0; md_rem[m] = 0;
        end else begin
            case (md_st[m])
                0: begin
                    e0 = ch0_req && (ch0_len != 0);
                    e1 = ch1_req && (ch1_len != 0);
                    if (e0 || e1) begin
                        if (e0 && e1) w = (m == 1) ? 0 : 1 - md_last[m];
                        else          w = e0 ? 0 : 1;
                        md_own[m] = w;
                        md_rem[m] = (w == 0) ? int'(ch0_len) : int'(ch1_len);
                        md_cnt[m] = 0;
                        md_sel[m] = (w == 0);
                        md_st[m]  = 1;
                    end
                end
                1: begin
                    if (beat_ack) begin
                        md_cnt[m] = (md_cnt[m] + 1) % 256;
                        md_rem[m] = md_rem[m] - 1;
                    end
                    if (beat_ack && md_rem[m] == 0) begin
                        md_st[m] = 2; md_done[m] = 1'b1; md_last[m] = md_own[m];
                    end else if (!rq[md_own[m]]) begin
                        md_st[m] = 2; md_abort[m] = 1'b1; md_last[m] = md_own[m];
                    end
                end
                default: md_st[m] = 0;
            endcase
        end
    endtask

    function automatic logic [13:0] model_out(input int m);
        logic [7:0] c;
        c = md_cnt[m][7:0];
        return {md_st[m] == 1 && md_own[m] == 0, md_st[m] == 1 && md_own[m] == 1,
                md_sel[m], md_st[m] == 1, c, md_done[m], md_abort[m]};
    endfunction

    logic [13:0] exp_rr[$];
    logic [13:0] exp_fp[$];

    // One clock: predict, let the edge happen, compare, log finished bursts.
    task automatic tick();
        for (int m = 0; m < 2; m++) model_step(m);
        exp_rr.push_back(model_out(0));
        exp_fp.push_back(model_out(1));
        @(posedge clk);
        #1;
        chk("rr_sb", rr_vec, exp_rr.pop_front());
        chk("fp_sb", fp_vec, exp_fp.pop_front());
        if (rr_burst_done || rr_burst_abort)
            $display("[%0t] rr burst %s beats=%0d", $time, rr_burst_done ? "complete" : "abort", rr_beat_cnt);
        if (fp_burst_done || fp_burst_abort)
            $display("[%0t] fp burst %s beats=%0d", $time, fp_burst_done ? "complete" : "abort", fp_beat_cnt);
    endtask

    initial begin
        int nrise, zeros, gap, code_rr, code_fp;
        logic prev;
        logic fp_ch1_seen;
        int pat[4];

        // Reset state
        rst = 1'b1;
        tick();
        tick();
        chk("rst_rr", rr_vec, 14'd0);
        chk("rst_fp", fp_vec, 14'd0);
        rst = 1'b0;

        // Single-channel burst, len 4, continuous ack
        ch0_req = 1'b1; ch0_len = 8'd4; beat_ack = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t1_gnt", rr_ch0_gnt, 1);
            chk("t1_sel", rr_sel, 1);
            chk("t1_cnt", rr_beat_cnt, i);
        end
        tick();
        chk("t1_done", rr_burst_done, 1);
        chk("t1_gnt_off", rr_ch0_gnt, 0);
        chk("t1_cnt_final", rr_beat_cnt, 4);
        ch0_req = 1'b0;
        tick();
        chk("t1_pulse_end", rr_burst_done, 0);

        // Round-robin versus fixed priority, both channels len 2
        rst = 1'b1; tick(); rst = 1'b0;
        ch0_req = 1'b1; ch1_req = 1'b1; ch0_len = 8'd2; ch1_len = 8'd2; beat_ack = 1'b1;
        nrise = 0; zeros = 0; gap = -1; prev = 1'b0;
        code_rr = 1; code_fp = 1; fp_ch1_seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (rr_bus_req && !prev) begin
                code_rr = code_rr * 2 + int'(rr_sel);
                if (nrise == 1) gap = zeros;
                nrise++;
                zeros = 0;
            end else if (!rr_bus_req) begin
                zeros++;
            end
            prev = rr_bus_req;
            if (fp_bus_req && fp_beat_cnt == 0) code_fp = code_fp * 2 + int'(fp_sel);
            if (fp_ch1_gnt) fp_ch1_seen = 1'b1;
        end
        // Leading 1 marks the length: 4'b1101 = ch0, ch1, ch0.
        chk("rr_order", code_rr, 32'hD);
        chk("rr_gap", gap, 2);
        chk("fp_order", code_fp, 32'hF);
        chk("fp_no_ch1", fp_ch1_seen, 0);
        ch0_req = 1'b0; ch1_req = 1'b0;
        tick(); tick(); tick();

        // Stall and abort on ch1; len change after grant must be ignored
        ch1_req = 1'b1; ch1_len = 8'd5; beat_ack = 1'b1;
        tick();
        chk("t3_gnt", rr_ch1_gnt, 1);
        chk("t3_sel", rr_sel, 0);
        ch1_len = 8'd1;
        pat = '{1, 0, 0, 1};
        for (int i = 0; i < 4; i++) begin
            beat_ack = pat[i][0];
            tick();
        end
        chk("t3_cnt", rr_beat_cnt, 2);
        chk("t3_still_gnt", rr_ch1_gnt, 1);
        ch1_req = 1'b0; beat_ack = 1'b0;
        tick();
        chk("t3_abort", rr_burst_abort, 1);
        chk("t3_no_done", rr_burst_done, 0);
        chk("t3_cnt_hold", rr_beat_cnt, 2);
        tick();
        chk("t3_abort_end", rr_burst_abort, 0);

        // Zero length never granted; completion beats a same-cycle drop
        ch0_req = 1'b1; ch0_len = 8'd0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t4_zero_rr", rr_bus_req, 0);
            chk("t4_zero_fp", fp_bus_req, 0);
        end
        ch1_req = 1'b1; ch1_len = 8'd1; beat_ack = 1'b0;
        tick();
        chk("t4_gnt", rr_ch1_gnt, 1);
        ch1_req = 1'b0; beat_ack = 1'b1;
        tick();
        chk("t4_done_rr", rr_burst_done, 1);
        chk("t4_abort_rr", rr_burst_abort, 0);
        chk("t4_done_fp", fp_burst_done, 1);
        beat_ack = 1'b0;
        tick();
        chk("t4_zero_after", rr_ch0_gnt, 0);
        ch0_req = 1'b0;
        tick();

        // Reset mid-burst, after a ch0 burst has set the round-robin history
        ch0_req = 1'b1; ch0_len = 8'd1; beat_ack = 1'b1;
        tick();
        ch0_len = 8'd8;
        tick(); tick(); tick();
        tick(); tick(); tick();
        chk("t5_cnt3", rr_beat_cnt, 3);
        chk("t5_gnt", rr_ch0_gnt, 1);
        rst = 1'b1;
        tick();
        chk("t5_rst_rr", rr_vec, 14'd0);
        chk("t5_rst_fp", fp_vec, 14'd0);
        rst = 1'b0; ch1_req = 1'b1; ch0_len = 8'd2; ch1_len = 8'd2;
        tick();
        chk("t5_tie_ch0", rr_ch0_gnt, 1);
        chk("t5_tie_not_ch1", rr_ch1_gnt, 0);
        ch0_req = 1'b0; ch1_req = 1'b0;
        tick(); tick(); tick();

        // Random traffic checked against the model
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 7) == 0) ch0_req = ~ch0_req;
            if ($urandom_range(0, 7) == 0) ch1_req = ~ch1_req;
            ch0_len  = 8'($urandom_range(0, 3));
            ch1_len  = 8'($urandom_range(0, 3));
            beat_ack = 1'($urandom_range(0, 1));
            rst      = ($urandom_range(0, 99) == 0);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
